// File: rtl/sign_packer.sv
// Snapshots the counter-bank sign vector a fixed delay after a job ends and
// streams it out as OUT_W-bit words over a valid/ready interface.
module sign_packer #(
  parameter int unsigned DIM   = 1024,
  parameter int unsigned OUT_W = 64,
  parameter int unsigned DELAY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic [DIM-1:0]   sign_in,
  output logic [OUT_W-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned Words = DIM / OUT_W;
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);

  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [DIM-1:0]   snap_q;
  logic [OUT_W-1:0] tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             overrun_q, overrun_d;
  logic             capture;
  logic             hs;

  // Next-state, capture strobe and registered-output updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    capture   = 1'b0;
    hs        = tvalid_q & m_tready;
    // A done outside IDLE (even on the last handshake) is dropped and flagged.
    overrun_d = overrun_q | (done & (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (done) begin
          if (DELAY == 0) begin
            capture = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(DELAY - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSend: begin
        if (hs) begin
          if (tlast_q) begin
            state_d  = StIdle;
            idx_d    = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            idx_d   = idx_q + 1'b1;
            tdata_d = snap_q[int'(idx_d) * OUT_W +: OUT_W];
            tlast_d = (idx_d == LastIdx);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Word 0 comes straight from sign_in so it is valid the cycle after capture.
    if (capture) begin
      state_d  = StSend;
      idx_d    = '0;
      tdata_d  = sign_in[OUT_W-1:0];
      tvalid_d = 1'b1;
      tlast_d  = (Words == 1);
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      overrun_q <= overrun_d;
    end
  end

  // Snapshot register; no reset needed since it is only read after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      snap_q <= sign_in;
    end
  end

  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign m_tlast  = tlast_q;
  assign busy     = (state_q != StIdle);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_sign_packer.sv
// Directed bench for sign_packer: DELAY=3 instance (u0) and DELAY=0 instance (u1)
// checked every cycle against a timestamp/snapshot model, plus literal checks.
module tb_sign_packer;

  localparam int DIM   = 1024;
  localparam int W     = 64;
  localparam int WORDS = DIM / W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           done0, done1, rdy0, rdy1;
  logic [DIM-1:0] sign0, sign1;
  logic [W-1:0]   data0, data1;
  logic           v0, v1, l0, l1, b0, b1, o0, o1;

  sign_packer #(.DIM(DIM), .OUT_W(W), .DELAY(3)) u0 (
    .clk(clk), .rst(rst), .done(done0), .sign_in(sign0), .m_tdata(data0), .m_tvalid(v0),
    .m_tready(rdy0), .m_tlast(l0), .busy(b0), .overrun(o0)
  );

  sign_packer #(.DIM(DIM), .OUT_W(W), .DELAY(0)) u1 (
    .clk(clk), .rst(rst), .done(done1), .sign_in(sign1), .m_tdata(data1), .m_tvalid(v1),
    .m_tready(rdy1), .m_tlast(l1), .busy(b1), .overrun(o1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a job accepted at cycle c samples sign_in at cycle c+DELAY, then the
  // snapshot's words are offered in order, one per accepting cycle.
  int             cyc = 0;
  logic           mbusy[2];
  logic           movr[2];
  logic           mact[2];
  int             midx[2];
  int             mst[2];
  logic [DIM-1:0] msnap[2];

  task automatic model_step(input int i, input logic d, input logic [DIM-1:0] s,
                            input logic r);
    logic was;
    if (rst) begin
      mbusy[i] = 1'b0; movr[i] = 1'b0; mact[i] = 1'b0; midx[i] = 0; mst[i] = -1;
    end else begin
      was = mbusy[i];
      if (mact[i] && r) begin
        if (midx[i] == WORDS - 1) begin
          mact[i] = 1'b0; mbusy[i] = 1'b0; midx[i] = 0;
        end else begin
          midx[i]++;
        end
      end
      if (d) begin
        if (was) movr[i] = 1'b1;
        else begin
          mbusy[i] = 1'b1;
          mst[i]   = cyc + ((i == 0) ? 3 : 0);
        end
      end
      if (mst[i] == cyc) begin
        msnap[i] = s; mact[i] = 1'b1; midx[i] = 0; mst[i] = -1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, done0, sign0, rdy0);
    model_step(1, done1, sign1, rdy1);
    cyc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("valid0", v0, mact[0]);
    check("busy0", b0, mbusy[0]);
    check("ovr0", o0, movr[0]);
    if (mact[0]) begin
      check("data0", data0, msnap[0][midx[0]*W +: W]);
      check("last0", l0, midx[0] == WORDS - 1);
    end
    check("valid1", v1, mact[1]);
    check("busy1", b1, mbusy[1]);
    check("ovr1", o1, movr[1]);
    if (mact[1]) begin
      check("data1", data1, msnap[1][midx[1]*W +: W]);
      check("last1", l1, midx[1] == WORDS - 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  logic [DIM-1:0] pat, ramp;

  // One frame on u0: done in the current cycle t, then ncyc cycles observed.
  task automatic frame(input int bp, input int xdone_k, input int rst_words, input int win,
                       input logic [DIM-1:0] p, input int ncyc,
                       output int first_v, output int nwords, output int nlast,
                       output int last_k, output int fall_k, output logic [63:0] w0);
    logic        do_rst, rst_prev, heldv;
    logic [63:0] held, expw;
    first_v = -1; nwords = 0; nlast = 0; last_k = -1; fall_k = -1; w0 = '0;
    do_rst = 1'b0; rst_prev = 1'b0; heldv = 1'b0; held = '0;
    done0 = 1'b1;
    sign0 = win ? '0 : p;
    rdy0  = bp ? 1'b0 : 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      done0 = (k == xdone_k);
      if (win != 0) sign0 = (k == 3) ? '1 : '0;
      rdy0 = bp ? (k % 2 == 1) : 1'b1;
      rst  = do_rst;
      do_rst = 1'b0;
      @(negedge clk);
      if (rst_prev) begin
        check("rst_valid", v0, 1'b0);
        check("rst_busy", b0, 1'b0);
        check("rst_ovr", o0, 1'b0);
      end
      rst_prev = rst;
      if (heldv && !rst) check("hold", data0, held);
      heldv = v0 && !rdy0;
      held  = data0;
      if (v0 && first_v < 0) first_v = k;
      if (!b0 && fall_k < 0 && k > 1) fall_k = k;
      if (v0 && rdy0 && !rst) begin
        expw = (win != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : p[nwords*W +: W];
        check("word", data0, expw);
        if (nwords == 0) w0 = data0;
        if (l0) begin
          nlast++;
          last_k = k;
          check("last_pos", 64'(nwords), 64'(WORDS - 1));
        end
        nwords++;
        if (nwords == rst_words) do_rst = 1'b1;
      end
    end
    done0 = 1'b0;
    rst   = 1'b0;
    rdy0  = 1'b1;
  endtask

  int          fv, nw, nl, lk, fk;
  logic [63:0] w0;

  initial begin
    rst = 1'b1; done0 = 1'b0; done1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
    sign0 = '0; sign1 = '0;
    for (int i = 0; i < DIM; i++) pat[i] = (i % 3 == 0);
    for (int k = 0; k < WORDS; k++)
      ramp[k*W +: W] = 64'h0706_0504_0302_0100 + 64'(k) * 64'h0808_0808_0808_0808;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid0", v0, 1'b0);
    check("reset_data0", data0, 64'h0);
    check("reset_busy0", b0, 1'b0);
    check("reset_ovr0", o0, 1'b0);
    check("reset_valid1", v1, 1'b0);

    // Basic frame, tready held high.
    frame(0, -1, -1, 0, pat, 24, fv, nw, nl, lk, fk, w0);
    check("t1_first_valid", 64'(fv), 64'd4);
    check("t1_nwords", 64'(nw), 64'd16);
    check("t1_nlast", 64'(nl), 64'd1);
    check("t1_last_k", 64'(lk), 64'd19);
    check("t1_busy_fall", 64'(fk), 64'd20);
    check("t1_word0", w0, 64'h9249_2492_4924_9249);

    // Capture window: only the t+3 value of sign_in matters.
    frame(0, -1, -1, 1, pat, 24, fv, nw, nl, lk, fk, w0);
    check("t2_nwords", 64'(nw), 64'd16);
    check("t2_word0", w0, 64'hFFFF_FFFF_FFFF_FFFF);

    // Backpressure: tready 0,1,0,1... from t+4.
    frame(1, -1, -1, 0, ramp, 40, fv, nw, nl, lk, fk, w0);
    check("t3_first_valid", 64'(fv), 64'd4);
    check("t3_nwords", 64'(nw), 64'd16);
    check("t3_last_k", 64'(lk), 64'd35);
    check("t3_busy_fall", 64'(fk), 64'd36);
    check("t3_word0", w0, 64'h0706_0504_0302_0100);

    // Dropped done while busy, then a fresh job after busy falls.
    frame(0, 6, -1, 0, pat, 24, fv, nw, nl, lk, fk, w0);
    check("t4_nwords", 64'(nw), 64'd16);
    check("t4_busy_fall", 64'(fk), 64'd20);
    check("t4_overrun", o0, 1'b1);
    frame(0, -1, -1, 0, ramp, 24, fv, nw, nl, lk, fk, w0);
    check("t4b_nwords", 64'(nw), 64'd16);
    check("t4b_overrun_sticky", o0, 1'b1);

    // Reset after word 5 handshake, then a full frame from word 0.
    frame(0, -1, 6, 0, ramp, 12, fv, nw, nl, lk, fk, w0);
    check("t5_nwords", 64'(nw), 64'd6);
    frame(0, -1, -1, 0, pat, 24, fv, nw, nl, lk, fk, w0);
    check("t5b_nwords", 64'(nw), 64'd16);
    check("t5b_word0", w0, 64'h9249_2492_4924_9249);

    // DELAY=0: capture in the done cycle, valid next cycle.
    done1 = 1'b1;
    sign1 = {WORDS{64'hA5A5_A5A5_A5A5_A5A5}};
    @(posedge clk); #1;
    done1 = 1'b0;
    sign1 = '0;
    @(negedge clk);
    check("t6_valid", v1, 1'b1);
    check("t6_word0", data1, 64'hA5A5_A5A5_A5A5_A5A5);
    repeat (20) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t6_idle", b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
